imm_field_extender: RTL and testbench

- Pipelined immediate/offset extractor for the LC-3 datapath.
- Takes a raw instruction word and a field selector, slices the selected field (imm5, offset6, PCoffset9, PCoffset11, trapvect8, nibble), and zero- or sign-extends it to OUT_W bits.
- Supersedes the fixed-width combinational zero extenders: it adds run-time field selection, sign mode, a valid/ready handshake and a 2-entry skid buffer.
- Sits between the decode stage and the address/ALU operand muxes.

---
 rtl/lc3_ext_pkg.sv | 54 +++++
 rtl/ext_skid_buf.sv | 82 ++++++++
 rtl/imm_field_extender.sv | 71 +++++++
 tb/tb_imm_field_extender.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_ext_pkg.sv
// Shared definitions for the LC-3 immediate/offset extender.
// Holds the field-select encodings, the width of each field, and
// ext_field(), which slices one field out of an instruction word and
// extends it.
// ext_field() builds its result at EXT_MAX_W bits. Users keep the low
// OUT_W bits. Sign extension to the wide width followed by truncation
// gives the same bits as extending directly to OUT_W.
package lc3_ext_pkg;

    localparam logic [2:0] SEL_IMM5  = 3'd0;
    localparam logic [2:0] SEL_OFF6  = 3'd1;
    localparam logic [2:0] SEL_OFF9  = 3'd2;
    localparam logic [2:0] SEL_OFF11 = 3'd3;
    localparam logic [2:0] SEL_TRAP8 = 3'd4;
    localparam logic [2:0] SEL_NIB4  = 3'd5;

    localparam int FW_IMM5  = 5;
    localparam int FW_OFF6  = 6;
    localparam int FW_OFF9  = 9;
    localparam int FW_OFF11 = 11;
    localparam int FW_TRAP8 = 8;
    localparam int FW_NIB4  = 4;

    // Widest field in use; only these instruction bits are ever looked at.
    localparam int FIELD_SRC_W = FW_OFF11;
    localparam int EXT_MAX_W   = 64;

    typedef struct packed {
        logic                 err;
        logic [EXT_MAX_W-1:0] data;
    } ext_result_t;

    function automatic ext_result_t ext_field(
        input logic [FIELD_SRC_W-1:0] instr,
        input logic [2:0]             sel,
        input logic                   sign
    );
        ext_result_t r;
        r.err  = 1'b0;
        r.data = '0;
        case (sel)
            SEL_IMM5:  r.data = {{(EXT_MAX_W-FW_IMM5){sign & instr[FW_IMM5-1]}},   instr[FW_IMM5-1:0]};
            SEL_OFF6:  r.data = {{(EXT_MAX_W-FW_OFF6){sign & instr[FW_OFF6-1]}},   instr[FW_OFF6-1:0]};
            SEL_OFF9:  r.data = {{(EXT_MAX_W-FW_OFF9){sign & instr[FW_OFF9-1]}},   instr[FW_OFF9-1:0]};
            SEL_OFF11: r.data = {{(EXT_MAX_W-FW_OFF11){sign & instr[FW_OFF11-1]}}, instr[FW_OFF11-1:0]};
            // A trap vector is an unsigned table index, so sign mode never applies.
            SEL_TRAP8: r.data = {{(EXT_MAX_W-FW_TRAP8){1'b0}},                      instr[FW_TRAP8-1:0]};
            SEL_NIB4:  r.data = {{(EXT_MAX_W-FW_NIB4){sign & instr[FW_NIB4-1]}},   instr[FW_NIB4-1:0]};
            default:   r.err  = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ext_skid_buf.sv
// FIFO-ordered valid/ready output buffer with DEPTH entries (1 or 2).
// Ports:
//   clk, rst                   clock, async active-high reset
//   push_valid/push_ready      write side; push_ready is a register
//   push_data                  DATA_W word written on push
//   pop_valid/pop_ready        read side
//   pop_data                   head entry, read straight from storage
// Handshake: a beat moves on a rising edge where valid && ready. The
// source holds valid and data steady until that edge. pop_valid and
// pop_data come only from registers.
module ext_skid_buf #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > 2) begin : g_depth_check
        $error("ext_skid_buf: DEPTH must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              ready_q;
    logic              push;
    logic              pop;

    assign push       = push_valid && ready_q;
    assign pop        = (count != '0) && pop_ready;
    assign push_ready = ready_q;
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + PTR_W'(1);
            end
            count   <= count_nxt;
            // ready_q looks ahead from the next occupancy, so out_ready
            // never reaches push_ready through logic alone.
            ready_q <= (count_nxt < DEPTH_C);
        end
    end

endmodule

// File: rtl/imm_field_extender.sv
// Pipelined immediate/offset extractor for the LC-3 datapath.
// Slices the field chosen by in_sel from in_instr, extends it to OUT_W
// bits (sign or zero), and registers the result into a skid buffer.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   input handshake; in_ready is registered
//   in_instr            raw instruction word (INSTR_W)
//   in_sel              field select; 6 and 7 are illegal
//   in_sign             1 = sign-extend, 0 = zero-extend
//   out_valid/out_ready output handshake
//   out_data            extended field (OUT_W)
//   out_err             the beat carried an illegal select
// Handshake: a beat moves on a rising edge where valid && ready. The
// source holds its beat until that edge. Output data holds while
// out_valid && !out_ready.
module imm_field_extender
    import lc3_ext_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int OUT_W      = 16,
    parameter int SKID_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [2:0]         in_sel,
    input  logic               in_sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_err
);

    if (INSTR_W < FIELD_SRC_W) begin : g_instr_w_check
        $error("imm_field_extender: INSTR_W must be >= 11");
    end
    if (OUT_W < FIELD_SRC_W || OUT_W > EXT_MAX_W) begin : g_out_w_check
        $error("imm_field_extender: OUT_W must be in 11..64");
    end

    ext_result_t      ext_res;
    logic [OUT_W:0]   push_word;
    logic [OUT_W:0]   pop_word;
    // Instruction bits above the widest field and the extension bits
    // above OUT_W are not needed. They feed this sink on purpose.
    logic             unused_bits;

    assign ext_res     = ext_field(in_instr[FIELD_SRC_W-1:0], in_sel, in_sign);
    assign push_word   = {ext_res.err, ext_res.data[OUT_W-1:0]};
    assign unused_bits = ^{in_instr, ext_res.data};

    ext_skid_buf #(
        .DATA_W (OUT_W + 1),
        .DEPTH  (SKID_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (push_word),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (pop_word)
    );

    assign out_err  = pop_word[OUT_W];
    assign out_data = pop_word[OUT_W-1:0];

endmodule

// File: tb/tb_imm_field_extender.sv
module tb_imm_field_extender;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  in_sel;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];

  imm_field_extender #(.INSTR_W(16), .OUT_W(16), .SKID_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_sel    (in_sel),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: the transfer happens on the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h expected none", {out_err, out_data});
      end else begin
        chk("out_beat", {15'd0, out_err, out_data}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // driver: presents one beat and returns just after the edge that took it
  task automatic send_beat(input logic [15:0] instr, input logic [2:0] sel,
                           input logic sign, input logic [16:0] exp);
    int n = 0;
    in_instr = instr;
    in_sel   = sel;
    in_sign  = sign;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] s_instr;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_sel    = '0;
    in_sign   = 1'b0;
    out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // imm5 sign/zero, checking one-cycle latency
    send_beat(16'h0015, 3'd0, 1'b1, {1'b0, 16'hFFF5});
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    idle(1);
    send_beat(16'h0015, 3'd0, 1'b0, {1'b0, 16'h0015});
    send_beat(16'hF0A5, 3'd4, 1'b1, {1'b0, 16'h00A5});
    send_beat(16'h0C00, 3'd3, 1'b1, {1'b0, 16'hFC00});
    send_beat(16'h0020, 3'd1, 1'b1, {1'b0, 16'hFFE0});
    send_beat(16'h0007, 3'd5, 1'b1, {1'b0, 16'h0007});
    idle(2);
    drain("drain_basic");

    // back-pressure: A then B with out_ready low
    out_ready = 1'b0;
    send_beat(16'h000A, 3'd5, 1'b1, {1'b0, 16'hFFFA});
    send_beat(16'h001A, 3'd1, 1'b0, {1'b0, 16'h001A});
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("held_data", out_data, 16'hFFFA);
    repeat (3) @(negedge clk);
    chk("held_data_later", out_data, 16'hFFFA);
    chk("held_err_later", out_err, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_backpressure");
    idle(2);

    // streaming: 20 back-to-back beats
    for (int i = 0; i < 20; i++) begin
      s_instr = 16'h00F8 + 16'(i);
      send_beat(s_instr, 3'd0, 1'b1, {1'b0, {11{s_instr[4]}}, s_instr[4:0]});
      if (i > 0) begin
        chk("stream_in_ready", in_ready, 1);
        chk("stream_out_valid", out_valid, 1);
      end
    end
    idle(2);
    drain("drain_stream");

    // illegal selects followed by a legal beat
    send_beat(16'hFFFF, 3'd6, 1'b1, {1'b1, 16'h0000});
    send_beat(16'h1234, 3'd7, 1'b0, {1'b1, 16'h0000});
    send_beat(16'h0123, 3'd2, 1'b1, {1'b0, 16'hFF23});
    idle(2);
    drain("drain_illegal");

    // reset mid-operation with two beats buffered
    out_ready = 1'b0;
    send_beat(16'h0003, 3'd0, 1'b0, {1'b0, 16'h0003});
    send_beat(16'h0004, 3'd0, 1'b0, {1'b0, 16'h0004});
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_empty", out_valid, 0);
    send_beat(16'h01F0, 3'd2, 1'b1, {1'b0, 16'hFFF0});
    idle(3);
    drain("drain_after_rst");
    chk("final_idle_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
